// File: rtl/data_bus.sv
// Data-side memory subsystem for the single-cycle RV32I core: word RAM, a UART
// transmitter fed by a small TX FIFO, and a free-running cycle counter.
module data_bus #(
    parameter int MEM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        uart_tx
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]   CLK_ONE  = CW'(1);
    localparam logic [CW-1:0]   CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [29-AW:0]  RAM_HI   = {(30-AW){1'b0}};

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    logic [31:0]   mem_r [MEM_WORDS];
    logic [7:0]    fifo_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [PW:0]   count_r;
    logic          ovf_r;
    logic [31:0]   cycle_r;
    state_t        state_r;
    logic [CW-1:0] clkcnt_r;
    logic [2:0]    bitcnt_r;
    logic [7:0]    shreg_r;
    logic          tx_r;

    logic          ram_hit_s, data_hit_s, stat_hit_s, cyc_hit_s;
    logic [AW-1:0] ram_idx_s;
    logic          full_s, empty_s, busy_s, push_req_s, push_s, pop_s, clk_last_s;
    logic          unused_s;

    assign unused_s   = ^addr[1:0];
    assign ram_hit_s  = (addr[31:AW+2] == RAM_HI);
    assign ram_idx_s  = addr[AW+1:2];
    assign data_hit_s = (addr[31:2] == 30'h2000_0000);
    assign stat_hit_s = (addr[31:2] == 30'h2000_0001);
    assign cyc_hit_s  = (addr[31:2] == 30'h2000_0002);

    assign full_s     = (count_r == CNT_FULL);
    assign empty_s    = (count_r == {(PW+1){1'b0}});
    assign busy_s     = (state_r != IDLE);
    assign clk_last_s = (clkcnt_r == CLK_LAST);
    assign push_req_s = we && data_hit_s;
    assign push_s     = push_req_s && !full_s;
    assign uart_tx    = tx_r;

    // Pop happens when the FSM launches a frame from IDLE or chains one from STOP.
    always_comb begin
        pop_s = 1'b0;
        if (!empty_s && (state_r == IDLE || (state_r == STOP && clk_last_s))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Zero-latency read mux; reads of an address being written see the old word.
    always_comb begin
        rdata = 32'h0;
        if (ram_hit_s) begin
            rdata = mem_r[ram_idx_s];
        end else if (stat_hit_s) begin
            rdata = {28'h0, ovf_r, busy_s, empty_s, full_s};
        end else if (cyc_hit_s) begin
            rdata = cycle_r;
        end else begin
            rdata = 32'h0;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (we && ram_hit_s) mem_r[ram_idx_s] <= wdata;
    end

    // FIFO storage; entries past the pointers are don't-care.
    always_ff @(posedge clock) begin
        if (push_s) fifo_r[wr_ptr_r] <= wdata[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow (a new overflow beats a clear).
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (push_req_s && full_s) begin
                ovf_r <= 1'b1;
            end else if (we && stat_hit_s && wdata[3]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) cycle_r <= 32'h0;
        else       cycle_r <= cycle_r + 32'h1;
    end

    // UART 8N1 transmitter; tx_r is loaded with the level of the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            tx_r     <= 1'b1;
            clkcnt_r <= {CW{1'b0}};
            bitcnt_r <= 3'd0;
            shreg_r  <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (!empty_s) begin
                        shreg_r  <= fifo_r[rd_ptr_r];
                        clkcnt_r <= {CW{1'b0}};
                        state_r  <= START;
                        tx_r     <= 1'b0;
                    end
                end
                START: begin
                    if (clk_last_s) begin
                        clkcnt_r <= {CW{1'b0}};
                        bitcnt_r <= 3'd0;
                        state_r  <= DATA;
                        tx_r     <= shreg_r[0];
                    end else begin
                        clkcnt_r <= clkcnt_r + CLK_ONE;
                    end
                end
                DATA: begin
                    if (clk_last_s) begin
                        clkcnt_r <= {CW{1'b0}};
                        if (bitcnt_r == 3'd7) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bitcnt_r <= bitcnt_r + 3'd1;
                            shreg_r  <= {1'b0, shreg_r[7:1]};
                            tx_r     <= shreg_r[1];
                        end
                    end else begin
                        clkcnt_r <= clkcnt_r + CLK_ONE;
                    end
                end
                STOP: begin
                    if (clk_last_s) begin
                        clkcnt_r <= {CW{1'b0}};
                        if (!empty_s) begin
                            shreg_r <= fifo_r[rd_ptr_r];
                            state_r <= START;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        clkcnt_r <= clkcnt_r + CLK_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end
endmodule
